// File: rtl/test_value_uart_tx.sv
// test_value_uart_tx: sends {SYNC_BYTE, test_value[15:8], test_value[7:0]} as 8N1 UART whenever the value changes or a send is forced
//   clk, reset (async, active-high), test_value[15:0], force_send (1-cycle pulse)
//   tx (serial out, idle high), busy (frame in progress), frames_sent[7:0] (completed frames, wraps)
module test_value_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] test_value,
  input  logic        force_send,
  output logic        tx,
  output logic        busy,
  output logic [7:0]  frames_sent
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [1:0] byte_idx;
  logic [15:0] snap, last_sent;
  logic force_pend, tick, go;
  logic [7:0] cur_byte;
  always_comb begin
    tick = cnt == CW'(CLKS_PER_BIT - 1);
    go = state == IDLE && (test_value != last_sent || force_pend || force_send);
    cur_byte = byte_idx == 2'd0 ? SYNC_BYTE : byte_idx == 2'd1 ? snap[15:8] : snap[7:0];
    nxt = state;
    case (state)
      IDLE:  nxt = go ? START : IDLE;
      START: nxt = tick ? DATA : START;
      DATA:  nxt = tick && bit_idx == 3'd7 ? STOP : DATA;
      STOP:  nxt = !tick ? STOP : byte_idx == 2'd2 ? IDLE : START;
      default: nxt = IDLE;
    endcase
    tx = state == START ? 1'b0 : state == DATA ? cur_byte[bit_idx] : 1'b1;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      snap <= '0;
      last_sent <= '0;
      force_pend <= 1'b0;
      frames_sent <= '0;
    end else begin
      state <= nxt;
      force_pend <= go ? 1'b0 : force_pend | force_send;
      cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
      if (go) begin
        snap <= test_value;
        last_sent <= test_value;
        byte_idx <= '0;
      end
      if (tick && state == START) bit_idx <= '0;
      if (tick && state == DATA) bit_idx <= bit_idx + 1'b1;
      if (tick && state == STOP) begin
        if (byte_idx == 2'd2) frames_sent <= frames_sent + 1'b1;
        else byte_idx <= byte_idx + 1'b1;
      end
    end
  end
endmodule
